// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter for a single shared memory with variable latency and a hung-memory timeout.
// Optional build macro ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed CPU priority.
module mem_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy,
  output logic          owner,
  output logic          err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic          we_reg, we_next;
  logic [AW-1:0] addr_reg, addr_next;
  logic [DW-1:0] wdata_reg, wdata_next;
  logic          owner_reg, owner_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic          err_reg, err_next;
  logic          grant;
  logic          capture;
  logic [DW-1:0] cap_data;
  logic          any_req;

  assign any_req = cpu_req | dma_req;

`ifdef ARB_ROUND_ROBIN_EN
  // last_reg: 0 = CPU served last, 1 = DMA; resets to DMA so the first tie goes to the CPU
  logic last_reg, last_next;

  assign grant     = (cpu_req & dma_req) ? ~last_reg : dma_req;
  assign last_next = (state_reg == IDLE && any_req) ? grant : last_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) last_reg <= 1'b1;
    else        last_reg <= last_next;
  end
`else
  assign grant = ~cpu_req;
`endif

  always_comb begin
    state_next = state_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    err_next   = err_reg;
    capture    = 1'b0;
    cap_data   = mem_rdata;
    case (state_reg)
      IDLE: begin
        if (any_req) begin
          state_next = BUSY;
          owner_next = grant;
          we_next    = grant ? dma_we    : cpu_we;
          addr_next  = grant ? dma_addr  : cpu_addr;
          wdata_next = grant ? dma_wdata : cpu_wdata;
          cnt_next   = 8'd0;
        end
      end
      BUSY: begin
        if (cnt_reg != 8'hFF) cnt_next = cnt_reg + 8'd1;
        // mem_ready takes precedence over a coinciding timeout
        if (mem_ready) begin
          capture    = 1'b1;
          state_next = DONE;
        end else if (cnt_reg == TO_LAST) begin
          capture    = 1'b1;
          cap_data   = '1;
          err_next   = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      owner_reg <= 1'b0;
      cnt_reg   <= 8'd0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
    end
  end

  // Per-requester read-data register and ack; index 0 = CPU, 1 = DMA
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : port_g
      logic [DW-1:0] rdata_reg;
      logic          ack;

      assign ack = (state_reg == DONE) && (owner_reg == 1'(gi));

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               rdata_reg <= '0;
        else if (capture && owner_reg == 1'(gi))  rdata_reg <= cap_data;
      end
    end
  endgenerate

  assign cpu_rdata = port_g[0].rdata_reg;
  assign dma_rdata = port_g[1].rdata_reg;
  assign cpu_ack   = port_g[0].ack;
  assign dma_ack   = port_g[1].ack;

  assign busy      = (state_reg != IDLE);
  assign mem_en    = (state_reg == BUSY);
  assign mem_we    = mem_en & we_reg;
  assign mem_addr  = addr_reg;
  assign mem_wdata = wdata_reg;
  assign owner     = owner_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed table-driven bench for mem_arbiter plus hand sequences for ties and reset during an access.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
  logic          cpu_ack, dma_ack;
  logic          mem_en, mem_we, mem_ready;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, owner, err;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .owner(owner), .err(err)
  );

  typedef struct {
    logic        dma;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          ready_cyc;   // BUSY cycle with mem_ready high; 0 = never
    int          ack_cyc;     // expected ack cycle after the grant edge
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];
  int total = 0;
  int passed = 0;
  logic [15:0] cpu_rd_m, dma_rd_m;
  logic        cpu_rd_v, dma_rd_v;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_txn(input int id, input vec_t v);
    @(posedge clk); #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    if (v.dma) begin
      dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wdata = v.wdata;
    end else begin
      cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
    end
    for (int k = 1; k <= v.ack_cyc; k++) begin
      @(posedge clk); #1;
      mem_ready = (k == v.ready_cyc);
      mem_rdata = mem_ready ? v.rdata : ~v.rdata;
      if (k < v.ack_cyc) begin
        check("busy_en", {28'd0, mem_en, mem_we, cpu_ack, dma_ack}, {28'd0, 1'b1, v.we, 2'b00});
        check("busy_addr", {16'd0, mem_addr}, {16'd0, v.addr});
        check("busy_wdata", {16'd0, mem_wdata}, {16'd0, v.wdata});
      end else begin
        check("ack", {29'd0, mem_en, cpu_ack, dma_ack}, {29'd0, 1'b0, ~v.dma, v.dma});
        check("owner", {31'd0, owner}, {31'd0, v.dma});
        check("err", {31'd0, err}, {31'd0, v.exp_err});
        if (v.dma) begin
          if (!v.we) check("dma_rdata", {16'd0, dma_rdata}, {16'd0, v.exp_rdata});
          if (cpu_rd_v) check("cpu_rdata_hold", {16'd0, cpu_rdata}, {16'd0, cpu_rd_m});
          dma_rd_m = v.exp_rdata; dma_rd_v = !v.we;
          dma_req = 1'b0;
        end else begin
          if (!v.we) check("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, v.exp_rdata});
          if (dma_rd_v) check("dma_rdata_hold", {16'd0, dma_rdata}, {16'd0, dma_rd_m});
          cpu_rd_m = v.exp_rdata; cpu_rd_v = !v.we;
          cpu_req = 1'b0;
        end
        mem_ready = 1'b0;
      end
    end
    $display("txn %0d: %s %s addr=%04h ack_cycle=%0d rdata_exp=%04h err_exp=%0d", id,
             v.dma ? "dma" : "cpu", v.we ? "wr" : "rd", v.addr, v.ack_cyc, v.exp_rdata, v.exp_err);
  endtask

  initial begin
    //          dma   we    addr      wdata     rdata     rdy ack exp_rdata err
    vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF,  1,  2, 16'hBEEF, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 16'h0020, 16'h1234, 16'h0000,  4,  5, 16'h0000, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 16'h00A0, 16'h5555, 16'h0000,  2,  3, 16'h0000, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 16'h0033, 16'h0000, 16'hCAFE,  3,  4, 16'hCAFE, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 16'h0044, 16'h0000, 16'h1357, 15, 16, 16'h1357, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 16'h0055, 16'h0000, 16'h2468,  0, 16, 16'hFFFF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 16'h0066, 16'h0000, 16'h0F0F,  1,  2, 16'h0F0F, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 16'h0077, 16'h0000, 16'h8421,  5,  6, 16'h8421, 1'b1};

    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    cpu_rd_m = '0; dma_rd_m = '0; cpu_rd_v = 1'b1; dma_rd_v = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check("rst_ctrl", {25'd0, mem_en, mem_we, cpu_ack, dma_ack, busy, owner, err}, 32'd0);
    check("rst_addr", {16'd0, mem_addr}, 32'd0);
    check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);
    reset = 1'b1;

    // Both requesters held continuously: one transaction per 3 cycles
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_addr = 16'h0100;
    dma_req = 1'b1; dma_addr = 16'h0200;
    mem_ready = 1'b1; mem_rdata = 16'hA5A5;
    for (int k = 1; k <= 14; k++) begin
      logic to_dma;
      @(posedge clk); #1;
`ifdef ARB_ROUND_ROBIN_EN
      to_dma = ((k / 3) % 2) == 1;
`else
      to_dma = 1'b0;
`endif
      if (k % 3 == 1)
        check("tie_addr", {16'd0, mem_addr}, to_dma ? 32'h0200 : 32'h0100);
      if (k % 3 == 2) begin
        check("tie_ack", {30'd0, cpu_ack, dma_ack}, {30'd0, ~to_dma, to_dma});
        check("tie_owner", {31'd0, owner}, {31'd0, to_dma});
        check("tie_rdata", {16'd0, to_dma ? dma_rdata : cpu_rdata}, 32'hA5A5);
      end else begin
        check("tie_noack", {30'd0, cpu_ack, dma_ack}, 32'd0);
      end
      $display("tie cycle %0d: cpu_ack=%0d dma_ack=%0d", k, cpu_ack, dma_ack);
    end
    cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
    cpu_rd_m = 16'hA5A5;
`ifdef ARB_ROUND_ROBIN_EN
    dma_rd_m = 16'hA5A5;
`endif

    for (int i = 0; i < 8; i++) do_txn(i, vecs[i]);

    // Reset asserted in BUSY cycle 3 of a 6-cycle DMA write
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 16'h0300; dma_wdata = 16'hABCD;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      check("pre_rst_en", {30'd0, mem_en, owner}, 32'd3);
    end
    reset = 1'b0;
    #1;
    check("arst_ctrl", {25'd0, mem_en, mem_we, cpu_ack, dma_ack, busy, owner, err}, 32'd0);
    check("arst_bus", {mem_addr, mem_wdata}, 32'd0);
    check("arst_rdata", {cpu_rdata, dma_rdata}, 32'd0);
    $display("reset during access: mem_en=%0d busy=%0d err=%0d", mem_en, busy, err);
    dma_req = 1'b0; dma_we = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("post_rst_quiet", {29'd0, busy, cpu_ack, dma_ack}, 32'd0);
    end
    cpu_rd_m = '0; dma_rd_m = '0; cpu_rd_v = 1'b1; dma_rd_v = 1'b1;
    begin
      vec_t r;
      r = '{1'b0, 1'b0, 16'h0400, 16'h0000, 16'h7777, 1, 2, 16'h7777, 1'b0};
      do_txn(8, r);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
